fetch_stage: RTL and testbench

//  - Instruction-fetch stage. Owns the PC register and the instruction-memory request/response handshake.
//  - Loads the IF/ID pipeline register.
//  - Consumes the redirect outputs of branch control (take_branch, next_pc, flush_pipe).
//  - Consumes the stall request from the hazard unit.
//  - Keeps at most one imem request outstanding; drops stale responses after a redirect.

---
 rtl/fetch_stage.sv | 136 +++++++++++++
 tb/tb_fetch_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding imem handshake
// and loads the IF/ID pipeline register, honouring redirect, stall and flush.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        take_branch,
  input  logic [31:0] next_pc,
  input  logic        flush_pipe,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] hold_reg, hold_next;
  logic        if_id_valid_reg, if_id_valid_next;
  logic [31:0] if_id_pc_reg, if_id_pc_next;
  logic [31:0] if_id_instr_reg, if_id_instr_next;

  logic        deliver;
  logic [31:0] deliver_instr;

  assign imem_req    = (state_reg == S_REQ) & ~rst;
  assign imem_addr   = pc_reg;
  assign if_id_valid = if_id_valid_reg;
  assign if_id_pc    = if_id_pc_reg;
  assign if_id_instr = if_id_instr_reg;

  // Fetch FSM: a redirect always wins over stall, response and hold.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    hold_next     = hold_reg;
    deliver       = 1'b0;
    deliver_instr = hold_reg;
    case (state_reg)
      S_REQ: begin
        if (take_branch) begin
          pc_next = next_pc;
          if (imem_gnt) state_next = S_DROP;
        end else if (imem_gnt) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (take_branch) begin
          pc_next    = next_pc;
          state_next = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          if (stall) begin
            hold_next  = imem_rdata;
            state_next = S_HOLD;
          end else begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            pc_next       = pc_reg + 32'd4;
            state_next    = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (take_branch) begin
          pc_next    = next_pc;
          state_next = S_REQ;
        end else if (!stall) begin
          deliver    = 1'b1;
          pc_next    = pc_reg + 32'd4;
          state_next = S_REQ;
        end
      end
      S_DROP: begin
        // A stale response arriving together with a new redirect is still the
        // one we were waiting to discard, so leave DROP rather than deadlock.
        if (take_branch) pc_next = next_pc;
        if (imem_rvalid) state_next = S_REQ;
      end
      default: state_next = S_REQ;
    endcase
  end

  // IF/ID: flush beats stall, stall beats a load, otherwise insert a bubble.
  always_comb begin
    if_id_valid_next = if_id_valid_reg;
    if_id_pc_next    = if_id_pc_reg;
    if_id_instr_next = if_id_instr_reg;
    if (flush_pipe) begin
      if_id_valid_next = 1'b0;
      if_id_instr_next = NOP_INSTR;
    end else if (stall) begin
      if_id_valid_next = if_id_valid_reg;
    end else if (deliver) begin
      if_id_valid_next = 1'b1;
      if_id_pc_next    = pc_reg;
      if_id_instr_next = deliver_instr;
    end else begin
      if_id_valid_next = 1'b0;
      if_id_instr_next = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_REQ;
      pc_reg          <= RESET_PC;
      hold_reg        <= 32'd0;
      if_id_valid_reg <= 1'b0;
      if_id_pc_reg    <= 32'd0;
      if_id_instr_reg <= NOP_INSTR;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      hold_reg        <= hold_next;
      if_id_valid_reg <= if_id_valid_next;
      if_id_pc_reg    <= if_id_pc_next;
      if_id_instr_reg <= if_id_instr_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an in-order imem responder plus a transaction-level
// model (queue of outstanding fetches, a held word, program-order PC).
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        take_branch = 1'b0;
  logic [31:0] next_pc = 32'd0;
  logic        flush_pipe = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .take_branch(take_branch),
    .next_pc(next_pc), .flush_pipe(flush_pipe),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fix_lat = 1;
  bit rand_lat = 1'b0;
  int gnt_pct = 100;
  int n_deliv = 0;

  // Model: outstanding fetches (stale once a redirect passes them), held word, IF/ID.
  typedef struct { logic [31:0] addr; bit stale; } mreq_t;
  typedef struct { int due; logic [31:0] addr; } ereq_t;
  mreq_t       m_q[$];
  ereq_t       env_q[$];
  logic [31:0] m_pc = RPC;
  bit          m_held = 1'b0;
  logic [31:0] m_held_addr = 32'd0;
  bit          m_if_valid = 1'b0;
  logic [31:0] m_if_pc = 32'd0;
  logic [31:0] m_if_instr = NOP;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit m_requesting();
    return (m_q.size() == 0) && !m_held && !rst;
  endfunction

  // One clock: imem responder drives gnt/rvalid, model advances, DUT clocks.
  task automatic step();
    bit          gnt_d, rv_d, redir, held_start, delivered;
    logic [31:0] dpc;
    int          lat;
    mreq_t       e, ne;
    ereq_t       ee;
    #1;
    rv_d = 1'b0;
    imem_rdata = $urandom;
    if (!rst && env_q.size() > 0 && env_q[0].due <= cyc) begin
      rv_d = 1'b1;
      imem_rdata = mem_word(env_q[0].addr);
    end
    gnt_d = (imem_req === 1'b1) && ($urandom_range(99) < gnt_pct);
    imem_gnt = gnt_d;
    imem_rvalid = rv_d;

    if (rst) begin
      m_q.delete();
      m_pc = RPC; m_held = 1'b0;
      m_if_valid = 1'b0; m_if_pc = 32'd0; m_if_instr = NOP;
      env_q.delete();
    end else begin
      redir = take_branch;
      held_start = m_held;
      delivered = 1'b0;
      dpc = 32'd0;
      if (rv_d && m_q.size() > 0) begin
        e = m_q.pop_front();
        if (!e.stale && !redir) begin
          if (stall) begin m_held = 1'b1; m_held_addr = e.addr; end
          else begin delivered = 1'b1; dpc = e.addr; end
        end
      end
      if (held_start) begin
        if (redir) m_held = 1'b0;
        else if (!stall) begin delivered = 1'b1; dpc = m_held_addr; m_held = 1'b0; end
      end
      if (gnt_d && held_start == 1'b0 && m_q.size() == 0 && !rv_d) begin
        ne.addr = m_pc; ne.stale = redir;
        m_q.push_back(ne);
      end
      if (redir) begin
        foreach (m_q[i]) m_q[i].stale = 1'b1;
        m_pc = next_pc;
      end else if (delivered) begin
        m_pc = m_pc + 32'd4;
      end
      if (flush_pipe) begin
        m_if_valid = 1'b0; m_if_instr = NOP;
      end else if (stall) begin
        m_if_valid = m_if_valid;
      end else if (delivered) begin
        m_if_valid = 1'b1; m_if_pc = dpc; m_if_instr = mem_word(dpc);
        n_deliv++;
      end else begin
        m_if_valid = 1'b0; m_if_instr = NOP;
      end
      if (rv_d) void'(env_q.pop_front());
      if (gnt_d) begin
        lat = rand_lat ? int'($urandom_range(3, 1)) : fix_lat;
        ee.due = cyc + lat; ee.addr = imem_addr;
        env_q.push_back(ee);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (if_id_valid === 1'b1)
      $display("txn cyc=%0d if_id pc=%08h instr=%08h", cyc, if_id_pc, if_id_instr);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", imem_req); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", if_id_valid); end
    checks++; if (if_id_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got=%08h want=0", if_id_pc); end
    checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL reset_instr got=%08h want=%08h", if_id_instr, NOP); end
    checks++; if (imem_addr !== RPC) begin errors++; $display("FAIL reset_addr got=%08h want=%08h", imem_addr, RPC); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_release_req got=%b want=1", imem_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    for (int k = 0; k < 3; k++) begin
      a = 32'(4 * k);
      checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin errors++; $display("FAIL seq_req k=%0d got=%b/%08h want=1/%08h", k, imem_req, imem_addr, a); end
      step();
      checks++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL seq_wait k=%0d req=%b valid=%b want 0/0", k, imem_req, if_id_valid); end
      step();
      checks++; if (if_id_valid !== 1'b1 || if_id_pc !== a || if_id_instr !== mem_word(a)) begin errors++; $display("FAIL seq_ifid k=%0d got=%b/%08h/%08h want=1/%08h/%08h", k, if_id_valid, if_id_pc, if_id_instr, a, mem_word(a)); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'd8) begin errors++; $display("FAIL stall_hold k=%0d got=%b/%08h want=1/00000008", k, if_id_valid, if_id_pc); end
    end
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'd12) begin errors++; $display("FAIL stall_pc got=%b/%08h want=0/0000000c", imem_req, imem_addr); end
    stall = 1'b0;
    step();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'd12 || if_id_instr !== mem_word(32'd12)) begin errors++; $display("FAIL stall_release got=%b/%08h/%08h want=1/0000000c/%08h", if_id_valid, if_id_pc, if_id_instr, mem_word(32'd12)); end
    checks++; if (imem_addr !== 32'd16) begin errors++; $display("FAIL stall_advance got=%08h want=00000010", imem_addr); end
  endtask

  task automatic test_redirect_wait();
    fix_lat = 2;
    step();
    take_branch = 1'b1; next_pc = 32'h100;
    step();
    take_branch = 1'b0;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_drop got=%b/%08h want=0/00000100", imem_req, imem_addr); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_id_valid !== 1'b0) begin errors++; $display("FAIL redir_req got=%b/%08h/%b want=1/00000100/0", imem_req, imem_addr, if_id_valid); end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (if_id_valid !== 1'b0 || if_id_instr === mem_word(32'd16)) begin errors++; $display("FAIL redir_stale k=%0d got=%b/%08h want=0/not-stale", k, if_id_valid, if_id_instr); end
    end
    step();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100 || if_id_instr !== mem_word(32'h100)) begin errors++; $display("FAIL redir_target got=%b/%08h/%08h want=1/00000100/%08h", if_id_valid, if_id_pc, if_id_instr, mem_word(32'h100)); end
    fix_lat = 1;
  endtask

  task automatic test_branch_rvalid();
    step();
    take_branch = 1'b1; next_pc = 32'h200;
    step();
    take_branch = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || if_id_valid !== 1'b0) begin errors++; $display("FAIL br_rvalid got=%b/%08h/%b want=1/00000200/0", imem_req, imem_addr, if_id_valid); end
  endtask

  task automatic test_flush_stall();
    step();
    step();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h200) begin errors++; $display("FAIL flush_pre got=%b/%08h want=1/00000200", if_id_valid, if_id_pc); end
    stall = 1'b1;
    step();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h200) begin errors++; $display("FAIL flush_stallhold got=%b/%08h want=1/00000200", if_id_valid, if_id_pc); end
    flush_pipe = 1'b1;
    step();
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || imem_req !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b/%08h/%b want=0/%08h/0", if_id_valid, if_id_instr, imem_req, NOP); end
    flush_pipe = 1'b0; stall = 1'b0;
    step();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h204 || imem_addr !== 32'h208) begin errors++; $display("FAIL flush_after got=%b/%08h/%08h want=1/00000204/00000208", if_id_valid, if_id_pc, imem_addr); end
  endtask

  task automatic test_wrap_and_reset();
    take_branch = 1'b1; next_pc = 32'hFFFF_FFFC;
    step();
    take_branch = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got=%b/%08h want=1/fffffffc", imem_req, imem_addr); end
    step();
    step();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'hFFFF_FFFC || imem_addr !== 32'd0) begin errors++; $display("FAIL wrap got=%b/%08h/%08h want=1/fffffffc/00000000", if_id_valid, if_id_pc, imem_addr); end
    fix_lat = 3;
    step();
    rst = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || if_id_pc !== 32'd0 || if_id_instr !== NOP) begin errors++; $display("FAIL wait_reset got=%b/%b/%08h/%08h want=0/0/0/%08h", imem_req, if_id_valid, if_id_pc, if_id_instr, NOP); end
    rst = 1'b0;
    fix_lat = 1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin errors++; $display("FAIL wait_reset_req got=%b/%08h want=1/%08h", imem_req, imem_addr, RPC); end
    step();
    step();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== RPC || if_id_instr !== mem_word(RPC)) begin errors++; $display("FAIL wait_reset_fetch got=%b/%08h/%08h want=1/%08h/%08h", if_id_valid, if_id_pc, if_id_instr, RPC, mem_word(RPC)); end
  endtask

  task automatic test_random();
    int start_deliv;
    start_deliv = n_deliv;
    rand_lat = 1'b1;
    gnt_pct = 70;
    for (int k = 0; k < 400; k++) begin
      checks++; if (imem_req !== m_requesting()) begin errors++; $display("FAIL rnd_req cyc=%0d got=%b want=%b", cyc, imem_req, m_requesting()); end
      checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%08h want=%08h", cyc, imem_addr, m_pc); end
      checks++; if (if_id_valid !== m_if_valid || if_id_instr !== m_if_instr) begin errors++; $display("FAIL rnd_ifid cyc=%0d got=%b/%08h want=%b/%08h", cyc, if_id_valid, if_id_instr, m_if_valid, m_if_instr); end
      if (m_if_valid) begin
        checks++; if (if_id_pc !== m_if_pc) begin errors++; $display("FAIL rnd_pc cyc=%0d got=%08h want=%08h", cyc, if_id_pc, m_if_pc); end
      end
      rst         = ($urandom_range(99) < 1);
      stall       = ($urandom_range(99) < 25);
      take_branch = ($urandom_range(99) < 12);
      flush_pipe  = ($urandom_range(99) < 10);
      next_pc     = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC : {$urandom_range(32'hFFFF, 0) , 16'h0} | {16'h0, 14'($urandom), 2'b00};
      step();
    end
    rst = 1'b0; stall = 1'b0; take_branch = 1'b0; flush_pipe = 1'b0;
    checks++; if (n_deliv - start_deliv < 20) begin errors++; $display("FAIL rnd_progress got=%0d want>=20", n_deliv - start_deliv); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_branch_rvalid();
    test_flush_stall();
    test_wrap_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
